// File: rtl/ctrl_pipeline.sv
// Control pipeline: ID/EX, EX/MEM, MEM/WB registers with hazard, flush and forward logic.
// Optional operand forwarding enabled by defining FWD_EN.
module ctrl_pipeline #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_reg_write,
    input  logic                  id_alu_src,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_branch,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output logic                  ex_reg_write,
    output logic                  ex_alu_src,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    logic                  ex_valid, mem_valid, wb_valid;
    logic [7:0]            ex_ctl_q;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [3:0]            mem_ctl_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic [1:0]            wb_ctl_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [7:0]            ex_ctl;
    logic                  use_ex, use_mem, load_use, hazard, load;

    // Invalid stages present all-zero control and indices
    assign ex_ctl = ex_valid ? ex_ctl_q : 8'd0;
    assign {ex_reg_write, ex_alu_src, ex_alu_op, ex_mem_read,
            ex_mem_write, ex_mem_to_reg, ex_branch} = ex_ctl;
    assign ex_rs1 = ex_valid ? ex_rs1_q : '0;
    assign ex_rs2 = ex_valid ? ex_rs2_q : '0;
    assign ex_rd  = ex_valid ? ex_rd_q  : '0;

    assign {mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg} =
        mem_valid ? mem_ctl_q : 4'd0;
    assign mem_rd = mem_valid ? mem_rd_q : '0;

    assign {wb_reg_write, wb_mem_to_reg} = wb_valid ? wb_ctl_q : 2'd0;
    assign wb_rd = wb_valid ? wb_rd_q : '0;

    assign use_ex = id_valid && ex_rd != '0 &&
                    (ex_rd == id_rs1 || ex_rd == id_rs2);
    assign use_mem = id_valid && mem_rd != '0 &&
                     (mem_rd == id_rs1 || mem_rd == id_rs2);
    assign load_use = ex_valid && ex_mem_read && use_ex;

`ifdef FWD_EN
    assign hazard = load_use;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs1)
            fwd_a = 2'b10;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs1)
            fwd_a = 2'b01;
        if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs2)
            fwd_b = 2'b10;
        else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs2)
            fwd_b = 2'b01;
    end
`else
    // Without forwarding every in-flight producer ahead of WB must drain
    assign hazard = load_use ||
                    (ex_valid && ex_reg_write && use_ex) ||
                    (mem_valid && mem_reg_write && use_mem);
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign flush = ex_valid && ex_branch && ex_branch_taken;
    assign stall = hazard && !flush;
    assign load  = id_valid && !hazard && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_ctl_q  <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_rd_q   <= '0;
            mem_valid <= 1'b0;
            mem_ctl_q <= '0;
            mem_rd_q  <= '0;
            wb_valid  <= 1'b0;
            wb_ctl_q  <= '0;
            wb_rd_q   <= '0;
        end else begin
            ex_valid <= load;
            if (load) begin
                ex_ctl_q <= {id_reg_write, id_alu_src, id_alu_op, id_mem_read,
                             id_mem_write, id_mem_to_reg, id_branch};
                ex_rs1_q <= id_rs1;
                ex_rs2_q <= id_rs2;
                ex_rd_q  <= id_rd;
            end else begin
                ex_ctl_q <= '0;
                ex_rs1_q <= '0;
                ex_rs2_q <= '0;
                ex_rd_q  <= '0;
            end
            mem_valid <= ex_valid;
            mem_ctl_q <= {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
            mem_rd_q  <= ex_rd;
            wb_valid  <= mem_valid;
            wb_ctl_q  <= {mem_reg_write, mem_mem_to_reg};
            wb_rd_q   <= mem_rd;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: vector table plus hand-written hazard sequences.
// Expectations follow FWD_EN when the macro is defined.
module tb_ctrl_pipeline;

`ifdef FWD_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif

    // ctl byte order: {reg_write, alu_src, alu_op[1:0], mem_read, mem_write, mem_to_reg, branch}
    localparam logic [7:0] ADD = 8'hA0;
    localparam logic [7:0] LW  = 8'hCA;
    localparam logic [7:0] BEQ = 8'h11;
    localparam logic [7:0] NOP = 8'h00;

    logic clk = 1'b0;
    logic rst;
    logic v, tk;
    logic [7:0] ctl;
    logic [4:0] rs1, rs2, rd;

    logic ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic wb_reg_write, wb_mem_to_reg;
    logic stall, flush;
    logic [1:0] fwd_a, fwd_b;

    logic [7:0] ex_ctl;
    logic [3:0] mem_ctl;
    logic [1:0] wb_ctl;
    assign ex_ctl = {ex_reg_write, ex_alu_src, ex_alu_op, ex_mem_read,
                     ex_mem_write, ex_mem_to_reg, ex_branch};
    assign mem_ctl = {mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg};
    assign wb_ctl = {wb_reg_write, wb_mem_to_reg};

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(v),
        .id_reg_write(ctl[7]), .id_alu_src(ctl[6]), .id_alu_op(ctl[5:4]),
        .id_mem_read(ctl[3]), .id_mem_write(ctl[2]), .id_mem_to_reg(ctl[1]),
        .id_branch(ctl[0]), .id_rs1(rs1), .id_rs2(rs2), .id_rd(rd),
        .ex_branch_taken(tk),
        .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd(wb_rd), .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic val, input logic t);
        ctl = c; rs1 = a; rs2 = b; rd = d; v = val; tk = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(NOP, 0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic       r, val, t;
        logic [7:0] c;
        logic [4:0] a, b, d;
        logic       cc;
        logic       st, fl;
        logic [1:0] fa, fb;
        logic [7:0] xc;
        logic [4:0] xa, xb, xd;
        logic [3:0] mc;
        logic [4:0] md;
        logic [1:0] wc;
        logic [4:0] wd;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic r, input logic [7:0] c, input logic [4:0] a,
                                input logic [4:0] b, input logic [4:0] d, input logic val,
                                input logic t, input logic cc, input logic st, input logic fl,
                                input logic [7:0] xc, input logic [4:0] xa, input logic [4:0] xb,
                                input logic [4:0] xd, input logic [3:0] mc, input logic [4:0] md,
                                input logic [1:0] wc, input logic [4:0] wd);
        vec_t e;
        e.r = r; e.c = c; e.a = a; e.b = b; e.d = d; e.val = val; e.t = t;
        e.cc = cc; e.st = st; e.fl = fl; e.fa = 2'b00; e.fb = 2'b00;
        e.xc = xc; e.xa = xa; e.xb = xb; e.xd = xd;
        e.mc = mc; e.md = md; e.wc = wc; e.wd = wd;
        return e;
    endfunction

    int cnt;

    initial begin
        rst = 1'b1;
        drive(NOP, 0, 0, 0, 1'b0, 1'b0);
        //            r  ctl  rs1 rs2 rd v  t  cc st fl  exctl rs1 rs2 rd memc md wbc wd
        tbl[0]  = mk(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 2'd0, 0);
        tbl[1]  = mk(1, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 2'd0, 0);
        tbl[2]  = mk(0, ADD, 1, 2, 5, 1, 0, 1, 0, 0, ADD,   1, 2, 5, 4'h0, 0, 2'd0, 0);
        tbl[3]  = mk(0, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 4'h8, 5, 2'd0, 0);
        tbl[4]  = mk(0, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 2'd2, 5);
        tbl[5]  = mk(0, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 2'd0, 0);
        tbl[6]  = mk(0, BEQ, 1, 2, 0, 1, 0, 1, 0, 0, BEQ,   1, 2, 0, 4'h0, 0, 2'd0, 0);
        tbl[7]  = mk(0, LW,  8, 0, 9, 1, 1, 1, 0, 1, 8'h00, 0, 0, 0, 4'h0, 0, 2'd0, 0);
        tbl[8]  = mk(0, BEQ, 1, 2, 0, 1, 0, 1, 0, 0, BEQ,   1, 2, 0, 4'h0, 0, 2'd0, 0);
        tbl[9]  = mk(0, LW,  8, 0, 9, 1, 0, 1, 0, 0, LW,    8, 0, 9, 4'h0, 0, 2'd0, 0);
        tbl[10] = mk(0, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 4'hD, 9, 2'd0, 0);
        tbl[11] = mk(0, LW,  1, 0, 0, 1, 0, 1, 0, 0, LW,    1, 0, 0, 4'h0, 0, 2'd3, 9);
        tbl[12] = mk(0, ADD, 0, 0, 4, 1, 0, 1, 0, 0, ADD,   0, 0, 4, 4'hD, 0, 2'd0, 0);
        tbl[13] = mk(0, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 4'h8, 4, 2'd3, 0);
        tbl[14] = mk(0, NOP, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 2'd2, 4);

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].r;
            if (tbl[i].r)
                drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            else
                drive(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].val, tbl[i].t);
            #1;
            if (tbl[i].cc) begin
                chk($sformatf("v%0d stall", i), stall, tbl[i].st);
                chk($sformatf("v%0d flush", i), flush, tbl[i].fl);
                chk($sformatf("v%0d fwd_a", i), fwd_a, tbl[i].fa);
                chk($sformatf("v%0d fwd_b", i), fwd_b, tbl[i].fb);
            end
            step();
            chk($sformatf("v%0d ex_ctl", i), ex_ctl, tbl[i].xc);
            chk($sformatf("v%0d ex_rs1", i), ex_rs1, tbl[i].xa);
            chk($sformatf("v%0d ex_rs2", i), ex_rs2, tbl[i].xb);
            chk($sformatf("v%0d ex_rd", i), ex_rd, tbl[i].xd);
            chk($sformatf("v%0d mem_ctl", i), mem_ctl, tbl[i].mc);
            chk($sformatf("v%0d mem_rd", i), mem_rd, tbl[i].md);
            chk($sformatf("v%0d wb_ctl", i), wb_ctl, tbl[i].wc);
            chk($sformatf("v%0d wb_rd", i), wb_rd, tbl[i].wd);
        end

        // Load-use: lw x3 then add x6,x3,x4
        idle(3);
        drive(LW, 1, 0, 3, 1'b1, 1'b0);
        step();
        drive(ADD, 3, 4, 6, 1'b1, 1'b0);
        #1;
        chk("lu stall1", stall, 1);
        chk("lu flush", flush, 0);
        step();
        chk("lu bubble", ex_ctl, 0);
        chk("lu bubble rd", ex_rd, 0);
        chk("lu stall2", stall, FW ? 0 : 1);
        step();
        if (!FW) begin
            chk("lu bubble2", ex_ctl, 0);
            chk("lu stall3", stall, 0);
            step();
        end
        chk("lu add ex_rd", ex_rd, 6);
        chk("lu add ex_ctl", ex_ctl, ADD);
        chk("lu fwd_a", fwd_a, FW ? 2'b01 : 2'b00);
        chk("lu fwd_b", fwd_b, 2'b00);

        // Two producers of x7 ahead of a consumer of x7,x7
        idle(3);
        drive(ADD, 1, 2, 7, 1'b1, 1'b0);
        step();
        drive(ADD, 1, 2, 7, 1'b1, 1'b0);
        step();
        drive(ADD, 7, 7, 8, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (!stall) break;
            cnt++;
            step();
        end
        chk("dp stall cycles", cnt, FW ? 0 : 2);
        step();
        chk("dp ex_rd", ex_rd, 8);
        chk("dp fwd_a", fwd_a, FW ? 2'b10 : 2'b00);
        chk("dp fwd_b", fwd_b, FW ? 2'b10 : 2'b00);

        // Taken branch and load-use condition in the same cycle
        idle(3);
        drive(8'h19, 1, 2, 3, 1'b1, 1'b0);
        step();
        drive(ADD, 3, 4, 6, 1'b1, 1'b1);
        #1;
        chk("sim flush", flush, 1);
        chk("sim stall", stall, 0);
        step();
        chk("sim ex_ctl", ex_ctl, 0);
        chk("sim ex_rd", ex_rd, 0);
        chk("sim mem_ctl", mem_ctl, 4'h4);
        chk("sim mem_rd", mem_rd, 3);

        // Reset while stalled
        idle(3);
        drive(LW, 1, 0, 3, 1'b1, 1'b0);
        step();
        drive(ADD, 3, 0, 6, 1'b1, 1'b0);
        #1;
        chk("rs stall", stall, 1);
        rst = 1'b1;
        step();
        chk("rs ex_ctl", ex_ctl, 0);
        chk("rs ex_rd", ex_rd, 0);
        chk("rs mem_ctl", mem_ctl, 0);
        chk("rs mem_rd", mem_rd, 0);
        chk("rs wb_ctl", wb_ctl, 0);
        drive(NOP, 0, 0, 0, 1'b0, 1'b0);
        #1;
        chk("rs stall clr", stall, 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
